// File: rtl/iir_pkg.sv
// Shared types and defaults for the biquad cascade scheduler.
package iir_pkg;

   localparam int unsigned DW_DEFAULT      = 24;
   localparam int unsigned NUM_SOS_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } sched_state_e;

   // Delay state of one second-order section.
   typedef struct packed {
      logic signed [DW_DEFAULT-1:0] w1;
      logic signed [DW_DEFAULT-1:0] w2;
   } sos_state_t;

endpackage

// File: rtl/iir_state_bank.sv
// Per-section delay-state bank: async read, one shift-write port, sync clear.
module iir_state_bank
   import iir_pkg::*;
#(
   parameter int unsigned NUM_SOS = NUM_SOS_DEFAULT,
   parameter int unsigned DW      = DW_DEFAULT,
   localparam int unsigned IW     = $clog2(NUM_SOS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          we_i,
   input  logic [IW-1:0] wr_idx_i,
   input  logic [DW-1:0] w0_i,
   input  logic [IW-1:0] rd_idx_i,
   output logic [DW-1:0] rd_w1_c,
   output logic [DW-1:0] rd_w2_c
);

   logic [DW-1:0] w1_q [NUM_SOS];
   logic [DW-1:0] w2_q [NUM_SOS];

   // Clear has priority over a write-back on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_SOS; k++) begin
            w1_q[k] <= '0;
            w2_q[k] <= '0;
         end
      end else if (clr_i) begin
         for (int k = 0; k < NUM_SOS; k++) begin
            w1_q[k] <= '0;
            w2_q[k] <= '0;
         end
      end else if (we_i) begin
         w2_q[wr_idx_i] <= w1_q[wr_idx_i];
         w1_q[wr_idx_i] <= w0_i;
      end
   end

   assign rd_w1_c = w1_q[rd_idx_i];
   assign rd_w2_c = w2_q[rd_idx_i];

endmodule

// File: rtl/iir_cascade_sched.sv
// Time-multiplexes one stateless biquad engine across NUM_SOS cascaded sections.
// Optional feature: define IIR_BYPASS_EN to add a bypass input that routes an
// accepted sample straight to the output without touching the engine or state.
module iir_cascade_sched
   import iir_pkg::*;
#(
   parameter int unsigned NUM_SOS = NUM_SOS_DEFAULT,
   parameter int unsigned DW      = DW_DEFAULT,
   parameter int unsigned TIMEOUT = 15,
   localparam int unsigned IW     = $clog2(NUM_SOS)
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef IIR_BYPASS_EN
   input  logic          bypass,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   input  logic          state_clr,
   output logic          eng_valid,
   output logic [IW-1:0] eng_sos_idx,
   output logic [DW-1:0] eng_x,
   output logic [DW-1:0] eng_w1,
   output logic [DW-1:0] eng_w2,
   input  logic          eng_valid_out,
   input  logic [DW-1:0] eng_y,
   input  logic [DW-1:0] eng_w0,
   output logic          busy,
   output logic          timeout_err
);

   localparam int unsigned   WDW      = 8;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SOS - 1);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

   sched_state_e  state_q, state_d;
   logic [DW-1:0] x_q, x_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          bank_we, load_eng;
   logic [DW-1:0] rd_w1, rd_w2;
   logic          in_ready_q, out_valid_q, busy_q, eng_valid_q;
   logic [IW-1:0] eng_idx_q;
   logic [DW-1:0] eng_x_q, eng_w1_q, eng_w2_q;

   iir_state_bank #(
      .NUM_SOS (NUM_SOS),
      .DW      (DW)
   ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (state_clr),
      .we_i     (bank_we),
      .wr_idx_i (idx_q),
      .w0_i     (eng_w0),
      .rd_idx_i (idx_d),
      .rd_w1_c  (rd_w1),
      .rd_w2_c  (rd_w2)
   );

   // Next-state, datapath capture and bank write-back decisions.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      idx_d      = idx_q;
      wd_d       = wd_q;
      err_d      = err_q;
      out_data_d = out_data_q;
      bank_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d   = in_data;
               idx_d = '0;
`ifdef IIR_BYPASS_EN
               if (bypass) begin
                  state_d    = OUT;
                  out_data_d = in_data;
               end else
`endif
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wd_d    = '0;
         end
         WAIT: begin
            if (eng_valid_out) begin
               bank_we = 1'b1;
               x_d     = eng_y;
               if (idx_q == LAST_IDX) begin
                  state_d    = OUT;
                  out_data_d = eng_y;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ISSUE;
               end
            end else if (wd_q == WD_LIMIT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Clear wipes state; outside IDLE it also drops the in-flight sample.
      if (state_clr) begin
         err_d   = 1'b0;
         bank_we = 1'b0;
         if (state_q != IDLE) begin
            state_d    = IDLE;
            out_data_d = out_data_q;
         end
      end
      load_eng = (state_d == ISSUE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         idx_q       <= '0;
         wd_q        <= '0;
         err_q       <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         eng_valid_q <= 1'b0;
         eng_idx_q   <= '0;
         eng_x_q     <= '0;
         eng_w1_q    <= '0;
         eng_w2_q    <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         idx_q       <= idx_d;
         wd_q        <= wd_d;
         err_q       <= err_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == OUT);
         busy_q      <= (state_d != IDLE);
         eng_valid_q <= load_eng;
         if (load_eng) begin
            eng_idx_q <= idx_d;
            eng_x_q   <= x_d;
            eng_w1_q  <= state_clr ? '0 : rd_w1;
            eng_w2_q  <= state_clr ? '0 : rd_w2;
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;
   assign eng_valid   = eng_valid_q;
   assign eng_sos_idx = eng_idx_q;
   assign eng_x       = eng_x_q;
   assign eng_w1      = eng_w1_q;
   assign eng_w2      = eng_w2_q;

endmodule

// File: doc/iir_cascade_sched.md
Name: iir_cascade_sched

Overview:
- Sequencer that time-multiplexes one shared biquad engine across NUM_SOS cascaded second-order sections.
- Accepts one input sample, runs it through sections 0..NUM_SOS-1 in order, and feeds each section's output into the next section's input.
- Owns the per-section delay-state bank (w1, w2). The engine is stateless: it receives w1/w2 and returns w0 and y.
- Sits between the sample source and the output sink, in front of the biquad engine.

Parameters:
- NUM_SOS, 4, number of cascaded sections (2..8).
- DW, 24, sample/state width, signed two's complement.
- TIMEOUT, 15, maximum cycles WAIT may last before abort (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  scheduler can accept a sample
- in_data  in  DW  input sample, signed
- out_valid  out  1  filtered sample valid
- out_ready  in  1  sink accepts output
- out_data  out  DW  filtered sample, signed
- state_clr  in  1  synchronous clear of the whole state bank
- eng_valid  out  1  one-cycle issue strobe to the engine
- eng_sos_idx  out  $clog2(NUM_SOS)  section index (coefficient select)
- eng_x  out  DW  section input
- eng_w1  out  DW  w1 of the current section
- eng_w2  out  DW  w2 of the current section
- eng_valid_out  in  1  engine result valid
- eng_y  in  DW  section output
- eng_w0  in  DW  new w0 computed by the engine
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on watchdog abort, cleared by state_clr

Behaviour:
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, out_data=0, eng_valid=0, eng_sos_idx=0, eng_x=0, busy=0, timeout_err=0, every w1/w2=0. Reset is legal mid-operation; any in-flight sample is discarded.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, latch in_data into the x register, set idx=0, go to ISSUE.
  - ISSUE: drive eng_valid=1 for exactly 1 cycle. eng_x=x, eng_sos_idx=idx, eng_w1/eng_w2 = bank[idx]. Go to WAIT and clear the watchdog.
  - WAIT: hold eng_* stable, with eng_valid=0.
    - When eng_valid_out=1: write bank[idx].w2 <= bank[idx].w1 and bank[idx].w1 <= eng_w0, and set x <= eng_y.
    - If idx=NUM_SOS-1, go to OUT. Otherwise idx++ and go to ISSUE.
  - OUT: out_valid=1 and out_data=x. Hold until out_ready=1, then go to IDLE. out_data stays stable while stalled.
- Latency: with engine latency L (cycles from eng_valid to eng_valid_out, L≥1), out_valid rises NUM_SOS*(L+1)+1 cycles after the in_valid&in_ready accept edge. Throughput is one sample per latency + 1 cycles, since IDLE costs 1 cycle.
- eng_valid_out outside WAIT is ignored.
- Watchdog: a counter increments every WAIT cycle. If it reaches TIMEOUT without eng_valid_out:
  - set timeout_err, discard the sample, go to IDLE;
  - bank entries already updated for this sample are kept.
- state_clr:
  - In IDLE: zeroes all bank entries and timeout_err next cycle.
  - Outside IDLE: additionally aborts the sample and returns to IDLE. No out_valid is produced.
  - state_clr together with a write-back on the same edge: the clear wins.
- in_valid while not IDLE is not accepted (in_ready=0). The source must hold the sample.
- No arithmetic in the scheduler. Data is passed through at full DW with no truncation; saturation belongs to the engine.

Optional Feature:
- Macro: IIR_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled in IDLE at accept.
  - If bypass=1, go directly to OUT with out_data=in_data (latency 1 cycle).
  - No eng_valid is issued and the state bank is untouched.
- Undefined: no bypass port, and every sample traverses all sections.

Decomposition:
- Package iir_pkg holds:
  - DW_DEFAULT=24 and NUM_SOS_DEFAULT=4;
  - the FSM state typedef (IDLE, ISSUE, WAIT, OUT);
  - the section-state struct {w1, w2}.
- One sub-module, iir_state_bank: NUM_SOS×2×DW registers with an async read at idx, a single write port (w1, w2 shift), and a synchronous clear.

Test Plan:
1. Single-sample cascade. Bench engine: L=2, y=x+w1, w0=x, NUM_SOS=4. Input in_data=100, zero state -> out_data=100 after 13 cycles. Bank[k] becomes w1=100, w2=0 for all k.
2. Second sample 50 after sample 1, same engine. Section outputs are 150, then 250, then 350, ending at 450, so out_data=450 -> bank[0].w2=100 and bank[0].w1=50.
3. Output backpressure: hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready=0. Release -> IDLE after 1 cycle.
4. Watchdog: engine never answers on section 2 -> timeout_err=1 after 15 WAIT cycles, FSM returns to IDLE, no out_valid, bank[0..1] updated and bank[2..3] unchanged.
5. Mid-flight clear: pulse state_clr during section 1's WAIT -> IDLE next cycle, all bank entries 0, timeout_err cleared, no output.
6. Bypass (IIR_BYPASS_EN defined): bypass=1 with in_data=-7 -> out_data=-7 one cycle later, no eng_valid pulse, bank unchanged.
